// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: sequencer states, SPI mode encodings
// and the supported word-width range.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // SPI modes encoded as {cpol, cpha}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: emits a one-cycle tick every divisor+1 cycles while enabled.
// The divisor is captured on load so it stays fixed for the whole transfer.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] div_r;
  logic [DIV_WIDTH-1:0] cnt_r;

  // Tick on the last cycle of each half period.
  always_comb begin
    tick = enable && (cnt_r == {DIV_WIDTH{1'b0}});
  end

  // Down-counter reloaded from the captured divisor after every tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= {DIV_WIDTH{1'b0}};
      cnt_r <= {DIV_WIDTH{1'b0}};
    end else if (load) begin
      div_r <= divisor;
      cnt_r <= divisor;
    end else if (enable) begin
      if (tick) begin
        cnt_r <= div_r;
      end else begin
        cnt_r <= cnt_r - 1'b1;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Parametrised SPI master: configurable width, SCLK divider, CPOL/CPHA mode,
// bit order and chip-select hold across multi-word frames. All outputs registered.
module spi_master
  import spi_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 raw_clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     data_tx,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 cpol,
  input  logic                 cpha,
  input  logic                 lsb_first,
  input  logic                 keep_cs,
  output logic [WIDTH-1:0]     data_rx,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 cs_n
);

  localparam int EDGE_W = $clog2(2 * WIDTH + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * WIDTH);

  state_t            state_r;
  logic [WIDTH-1:0]  tx_shift_r;
  logic [WIDTH-1:0]  rx_shift_r;
  logic [EDGE_W-1:0] edge_cnt_r;
  logic              cpol_r;
  logic              cpha_r;
  logic              lsb_first_r;
  logic              keep_cs_r;

  logic              tick_s;
  logic              load_s;
  logic              enable_s;
  logic [EDGE_W-1:0] next_edge_s;
  logic              sample_s;
  logic              launch_s;

  function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] drop_bit(input logic [WIDTH-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [WIDTH-1:0] push_bit(input logic [WIDTH-1:0] w, input logic b,
                                                input logic lsb);
    return lsb ? {b, w[WIDTH-1:1]} : {w[WIDTH-2:0], b};
  endfunction

  assign load_s   = start && (state_r == IDLE);
  assign enable_s = (state_r != IDLE);

  spi_clk_gen #(.DIV_WIDTH(DIV_WIDTH)) u_clk_gen (
    .clk     (raw_clk),
    .rst_n   (reset_n),
    .load    (load_s),
    .enable  (enable_s),
    .divisor (divisor),
    .tick    (tick_s)
  );

  // Classify the edge the next tick will produce: odd edges lead, even edges trail.
  always_comb begin
    next_edge_s = edge_cnt_r + 1'b1;
    sample_s    = next_edge_s[0] ^ cpha_r;
    if (!sample_s && !(!cpha_r && (next_edge_s == LAST_EDGE))) begin
      launch_s = 1'b1;
    end else begin
      launch_s = 1'b0;
    end
  end

  // Transfer sequencer; every output of the block is a register updated here.
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      tx_shift_r  <= {WIDTH{1'b0}};
      rx_shift_r  <= {WIDTH{1'b0}};
      edge_cnt_r  <= {EDGE_W{1'b0}};
      cpol_r      <= 1'b0;
      cpha_r      <= 1'b0;
      lsb_first_r <= 1'b0;
      keep_cs_r   <= 1'b0;
      data_rx     <= {WIDTH{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      cs_n        <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          sclk <= cpol;
          mosi <= 1'b0;
          if (start) begin
            cpol_r      <= cpol;
            cpha_r      <= cpha;
            lsb_first_r <= lsb_first;
            keep_cs_r   <= keep_cs;
            edge_cnt_r  <= {EDGE_W{1'b0}};
            rx_shift_r  <= {WIDTH{1'b0}};
            busy        <= 1'b1;
            cs_n        <= 1'b0;
            state_r     <= SETUP;
            // cpha=0 presents the first bit before the first (sampling) edge.
            if (cpha) begin
              mosi       <= 1'b0;
              tx_shift_r <= data_tx;
            end else begin
              mosi       <= pick_bit(data_tx, lsb_first);
              tx_shift_r <= drop_bit(data_tx, lsb_first);
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SETUP, SHIFT: begin
          if (tick_s) begin
            if (edge_cnt_r == LAST_EDGE) begin
              if (keep_cs_r) begin
                state_r <= IDLE;
                busy    <= 1'b0;
                done    <= 1'b1;
                data_rx <= rx_shift_r;
                mosi    <= 1'b0;
              end else begin
                state_r <= HOLD;
              end
            end else begin
              state_r    <= SHIFT;
              sclk       <= ~sclk;
              edge_cnt_r <= next_edge_s;
              if (sample_s) begin
                rx_shift_r <= push_bit(rx_shift_r, miso, lsb_first_r);
              end else begin
                rx_shift_r <= rx_shift_r;
              end
              if (launch_s) begin
                mosi       <= pick_bit(tx_shift_r, lsb_first_r);
                tx_shift_r <= drop_bit(tx_shift_r, lsb_first_r);
              end else begin
                tx_shift_r <= tx_shift_r;
              end
            end
          end else begin
            state_r <= state_r;
          end
        end
        HOLD: begin
          sclk <= cpol_r;
          if (tick_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            data_rx <= rx_shift_r;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
